comp_serial_frame: RTL and testbench
====================================

COMP_SERIAL_FRAME -- requirements
Module: comp_serial_frame

Interface
REQ-001 SHALL have parameter DIGIT_W, default 1: bits per serial digit, legal 1..16.
REQ-002 SHALL have parameter NUM_DIGITS, default 8: digits per operand frame, legal 2..256.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1: qualifies the current digit as the MSB digit of a new frame.
REQ-006 SHALL have port valid  input  1: a/b carry a digit this cycle.
REQ-007 SHALL have port a  input  DIGIT_W: operand A digit, frames sent MSB-digit first.
REQ-008 SHALL have port b  input  DIGIT_W: operand B digit, frames sent MSB-digit first.
REQ-009 SHALL have port busy  output  1: frame in progress.
REQ-010 SHALL have port done  output  1: one-cycle pulse, final result valid.
REQ-011 SHALL have ports lt, eq, gt  output  1 each: A<B, A==B, A>B over the digits accepted so far.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL accept a digit only on a cycle with valid=1; valid=0 cycles leave all state unchanged.
REQ-014 SHALL, on valid&start in any state, clear the digit counter, evaluate the digit as digit 0, enter RUN (or DONE if NUM_DIGITS digits are now complete).
REQ-015 SHALL ignore valid without start while in IDLE or DONE.
REQ-016 SHALL register lt/eq/gt one cycle after each accepted digit: while eq=1 the digit comparison sets lt/eq/gt; once eq=0, lt/gt hold.
REQ-017 SHALL keep exactly one of lt/eq/gt high at all times.
REQ-018 SHALL count accepted digits modulo NUM_DIGITS with a ceil(log2(NUM_DIGITS))-bit counter; on the NUM_DIGITS-th digit, enter DONE.
REQ-019 SHALL assert done for exactly the one cycle after the last digit's rising edge, with final lt/eq/gt visible that same cycle.
REQ-020 SHALL hold lt/eq/gt after done until the next accepted start digit.
REQ-021 SHALL leave DONE for IDLE after one cycle, unless a start digit arrives.
REQ-022 SHALL drive busy=1 in RUN only.
REQ-023 SHALL treat start during RUN as abort-and-restart: the partial frame is discarded and done is not pulsed for it.

Reset
REQ-024 SHALL, on reset asserted, immediately force IDLE, counter=0, busy=0, done=0, lt=0, eq=1, gt=0, including mid-frame.
REQ-025 SHALL ignore all inputs on the first clock edge after reset deassertion only if reset is still high at that edge.

Configuration
REQ-026 SHALL honour macro COMP_SERIAL_SIGNED_EN: when defined, operands are two's complement and digit 0's top bit is the sign, so the top bit of a and b is inverted before the digit 0 compare only.
REQ-027 SHALL, without COMP_SERIAL_SIGNED_EN, compare operands as unsigned, with no inversion logic present.

Structure
REQ-028 SHALL place the FSM state enum and default DIGIT_W/NUM_DIGITS constants in shared package comp_pkg.
REQ-029 SHALL use one combinational sub-module comp_digit (DIGIT_W-wide a, b -> dlt, deq, dgt) instantiated once.

Verification
REQ-030 SHALL cover: DIGIT_W=1, NUM_DIGITS=8, A=0x5A, B=0x5A -> done after 8th digit, eq=1, lt=gt=0.
REQ-031 SHALL cover: DIGIT_W=4, NUM_DIGITS=2, A=0x3F, B=0x40 -> lt=1 after digit 0, held, done with lt=1.
REQ-032 SHALL cover: signed build, DIGIT_W=4, NUM_DIGITS=2, A=0x80 (-128), B=0x01 -> lt=1; unsigned build with the same operands -> gt=1.
REQ-033 SHALL cover: valid gaps (valid=0 for 3 cycles between digits) -> result and done timing shift by gap, value unchanged.
REQ-034 SHALL cover: start at digit 4 of 8 -> no done for aborted frame, new frame completes 8 digits later with correct result.
REQ-035 SHALL cover: reset asserted mid-frame -> outputs at reset values asynchronously, next start frame compares correctly.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared definitions for the digit-serial frame comparator.
// Holds the FSM state encoding and the default frame geometry.
package comp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_DIGIT_W    = 1;
  localparam int DEF_NUM_DIGITS = 8;

endpackage

// File: rtl/comp_digit.sv
// Combinational magnitude compare of one DIGIT_W-wide digit pair.
module comp_digit
  import comp_pkg::*;
#(
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               dlt,
  output logic               deq,
  output logic               dgt
);

  assign dlt = (a < b);
  assign deq = (a == b);
  assign dgt = (a > b);

endmodule

// File: rtl/comp_serial_frame.sv
// Digit-serial, MSB-first frame comparator producing lt/eq/gt and a done pulse.
// Define COMP_SERIAL_SIGNED_EN to compare two's-complement operands.
//
// state | meaning
// IDLE  | waiting for a start digit
// RUN   | frame in progress, digits 1..NUM_DIGITS-1 expected
// DONE  | final result presented for one cycle (done=1)
module comp_serial_frame
  import comp_pkg::*;
#(
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               valid,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               busy,
  output logic               done,
  output logic               lt,
  output logic               eq,
  output logic               gt
);

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DIGIT_W-1:0] a_cmp;
  logic [DIGIT_W-1:0] b_cmp;
  logic               dlt;
  logic               deq;
  logic               dgt;
  logic               take_start;
  logic               take_next;

  assign take_start = valid & start;
  assign take_next  = valid & ~start & (state == ST_RUN);

`ifdef COMP_SERIAL_SIGNED_EN
  // Flipping the sign bit of the MSB digit turns a signed compare into unsigned.
  localparam logic [DIGIT_W-1:0] SIGN_MASK = DIGIT_W'(1) << (DIGIT_W - 1);
  assign a_cmp = take_start ? (a ^ SIGN_MASK) : a;
  assign b_cmp = take_start ? (b ^ SIGN_MASK) : b;
`else
  assign a_cmp = a;
  assign b_cmp = b;
`endif

  comp_digit #(
    .DIGIT_W (DIGIT_W)
  ) u_digit (
    .a   (a_cmp),
    .b   (b_cmp),
    .dlt (dlt),
    .deq (deq),
    .dgt (dgt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      lt    <= 1'b0;
      eq    <= 1'b1;
      gt    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (take_start) begin
        // A start digit always opens a fresh frame, aborting any partial one.
        lt    <= dlt;
        eq    <= deq;
        gt    <= dgt;
        cnt   <= CNT_W'(1);
        state <= ST_RUN;
        busy  <= 1'b1;
      end else if (take_next) begin
        if (eq) begin
          lt <= dlt;
          eq <= deq;
          gt <= dgt;
        end
        if (cnt == LAST_CNT) begin
          cnt   <= '0;
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (state == ST_DONE) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_comp_serial_frame.sv
// Self-checking bench: table-driven frames with a done-time scoreboard, plus corner sequences.
module tb_comp_serial_frame;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 1-bit digits, 8 digits per frame
  logic v8, s8, a8, b8;
  logic busy8, done8, lt8, eq8, gt8;
  // 4-bit digits, 2 digits per frame
  logic v2, s2;
  logic [3:0] a2, b2;
  logic busy2, done2, lt2, eq2, gt2;

  comp_serial_frame #(.DIGIT_W(1), .NUM_DIGITS(8)) u8 (
    .clk(clk), .reset(reset), .start(s8), .valid(v8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .lt(lt8), .eq(eq8), .gt(gt8)
  );

  comp_serial_frame #(.DIGIT_W(4), .NUM_DIGITS(2)) u2 (
    .clk(clk), .reset(reset), .start(s2), .valid(v2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .lt(lt2), .eq(eq2), .gt(gt2)
  );

  typedef struct {
    logic [2:0] res;
    int         cyc;
  } sb_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         gap;
    logic [2:0] exp_u;
    logic [2:0] exp_s;
  } vec_t;

  sb_t  q8[$];
  sb_t  q2[$];
  vec_t vt[8];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [2:0] model(input logic [7:0] a, input logic [7:0] b);
`ifdef COMP_SERIAL_SIGNED_EN
    if ($signed(a) < $signed(b)) return LT;
    if ($signed(a) > $signed(b)) return GT;
    return EQ;
`else
    if (a < b) return LT;
    if (a > b) return GT;
    return EQ;
`endif
  endfunction

  function automatic logic [2:0] pick(input logic [2:0] exp_u, input logic [2:0] exp_s);
`ifdef COMP_SERIAL_SIGNED_EN
    return exp_s;
`else
    return exp_u;
`endif
  endfunction

  always @(negedge clk) begin
    if (done8) begin
      sb_t e;
      if (q8.size() == 0) check("u8 unexpected done", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        check("u8 result", {29'd0, lt8, eq8, gt8}, {29'd0, e.res});
        check("u8 done cycle", cyc, e.cyc);
        check("u8 busy at done", {31'd0, busy8}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      sb_t e;
      if (q2.size() == 0) check("u2 unexpected done", 32'd1, 32'd0);
      else begin
        e = q2.pop_front();
        check("u2 result", {29'd0, lt2, eq2, gt2}, {29'd0, e.res});
        check("u2 done cycle", cyc, e.cyc);
      end
    end
  end

  // Sends ndig digits of an 8-bit frame to u8; the expected result is queued with the last digit.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input int gap,
                       input int ndig, input logic [2:0] exp, input bit push);
    for (int i = 0; i < ndig; i++) begin
      v8 = 1'b1;
      s8 = (i == 0);
      a8 = a[7-i];
      b8 = b[7-i];
      if (push && i == 7) q8.push_back('{exp, cyc + 1});
      @(posedge clk); #1;
      v8 = 1'b0;
      s8 = 1'b0;
      if (i < ndig - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b, input logic [2:0] exp);
    v2 = 1'b1; s2 = 1'b1; a2 = a[7:4]; b2 = b[7:4];
    @(posedge clk); #1;
    s2 = 1'b0; a2 = a[3:0]; b2 = b[3:0];
    q2.push_back('{exp, cyc + 1});
    @(posedge clk); #1;
    v2 = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q8.size() != 0 || q2.size() != 0) && k < 12) begin
      @(posedge clk); #1;
      k++;
    end
    check("scoreboard drained", q8.size() + q2.size(), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0] ra, rb;

    vt[0] = '{8'h5A, 8'h5A, 0, EQ, EQ};
    vt[1] = '{8'h00, 8'hFF, 0, LT, GT};
    vt[2] = '{8'h7F, 8'h80, 0, LT, GT};
    vt[3] = '{8'h12, 8'h11, 0, GT, GT};
    vt[4] = '{8'hFE, 8'hFF, 0, LT, LT};
    vt[5] = '{8'h80, 8'h81, 3, LT, LT};
    vt[6] = '{8'h01, 8'h00, 3, GT, GT};
    vt[7] = '{8'h5A, 8'h5A, 3, EQ, EQ};

    reset = 1'b1;
    v8 = 1'b0; s8 = 1'b0; a8 = 1'b0; b8 = 1'b0;
    v2 = 1'b0; s2 = 1'b0; a2 = 4'h0; b2 = 4'h0;
    #1;
    check("u8 reset state", {27'd0, busy8, done8, lt8, eq8, gt8}, 32'b00010);
    check("u2 reset state", {27'd0, busy2, done2, lt2, eq2, gt2}, 32'b00010);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // 0x3F vs 0x40: lt decided on digit 0 and held through done
    v2 = 1'b1; s2 = 1'b1; a2 = 4'h3; b2 = 4'h4;
    @(posedge clk); #1;
    check("u2 after digit0", {27'd0, busy2, done2, lt2, eq2, gt2}, 32'b10100);
    s2 = 1'b0; a2 = 4'hF; b2 = 4'h0;
    q2.push_back('{LT, cyc + 1});
    @(posedge clk); #1;
    v2 = 1'b0;
    @(posedge clk); #1;
    check("u2 hold after done", {27'd0, busy2, done2, lt2, eq2, gt2}, 32'b00100);
    v2 = 1'b1; a2 = 4'h0; b2 = 4'hF;
    @(posedge clk); #1;
    v2 = 1'b0;
    check("u2 idle ignores valid", {27'd0, busy2, done2, lt2, eq2, gt2}, 32'b00100);
    drain();

    // 0x80 vs 0x01: sign decides in the signed build
    send2(8'h80, 8'h01, pick(GT, LT));
    drain();

    foreach (vt[i]) begin
      send8(vt[i].a, vt[i].b, vt[i].gap, 8, pick(vt[i].exp_u, vt[i].exp_s), 1'b1);
      drain();
    end

    for (int r = 0; r < 4; r++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (r == 3) ? ra : 8'($urandom_range(0, 255));
      send8(ra, rb, r % 2, 8, model(ra, rb), 1'b1);
      send2(ra, rb, model(ra, rb));
      drain();
    end

    // Abort at digit 4: the partial frame must never pulse done
    send8(8'hFF, 8'h00, 0, 4, EQ, 1'b0);
    check("u8 busy mid abort", {31'd0, busy8}, 32'd1);
    send8(8'h3C, 8'h3D, 0, 8, LT, 1'b1);
    drain();

    // Asynchronous reset mid-frame, then a clean frame
    send8(8'hF0, 8'h0F, 0, 5, EQ, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("u8 async reset", {27'd0, busy8, done8, lt8, eq8, gt8}, 32'b00010);
    @(posedge clk); #1;
    reset = 1'b0;
    send8(8'hA5, 8'hA4, 0, 8, GT, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
